// File: rtl/trace_logger_mc.sv
// -----------------------------------------------------------------------------
// trace_logger_mc
//
// Multi-channel trace logger. Each of NCHAN tracers hands over one word at a
// time into a private one-entry slot. A round-robin arbiter merges the pending
// slots into a single DEPTH-entry ring buffer held in an external memory. A
// request/grant port reads the ring back out. A sticky trigger captures the
// write address at which it was seen. Once a programmable amount of
// post-trigger history has been written, the trigger freezes the ring.
//
// Optional feature macro: TRACE_LOGGER_MC_DROP_COUNT_EN
//   defined   : DROP_CNT_O counts dropped stores and saturates at 16'hFFFF
//   undefined : DROP_CNT_O is tied to zero
//
// Ports
//   CLK_I, RST_NI       clock, synchronous active-low reset
//   MODE_I              0 = trace-buffer, 1 = streaming (sampled in reset)
//   DELAY_I             post-trigger history ratio
//   RW_TURN_I           1 = write cycle, 0 = read cycle
//   WRITE_ALLOW_I       memory-side write permission
//   READ_ALLOW_I        memory-side read permission
//   WRITE_O             memory write strobe
//   WRITE_PTR_O         memory write address
//   DMEM_O              memory write data
//   READ_PTR_O          memory read address
//   DMEM_I              memory read data
//   STORE_I, DATA_I     per-channel store strobes and packed words
//   STORE_PERM_O        per-channel store permission
//   TRG_EVENT_I         trigger event
//   TRG_DELAYED_O       trigger seen and post-trigger history written
//   EVENT_ADDR_O        write pointer when the trigger was first seen
//   LOAD_REQUEST_I      readout request
//   LOAD_GRANT_O        one-cycle grant qualifying DATA_O
//   DATA_O              read data
//   LAST_CHAN_O         channel of the most recent ring write
//   DROP_CNT_O          dropped-store counter
// -----------------------------------------------------------------------------
module trace_logger_mc #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int NCHAN      = 2,
    parameter int CHAN_W     = (NCHAN > 1) ? $clog2(NCHAN) : 1,
    parameter int DELAY_BITS = 3
) (
    input  logic                    CLK_I,
    input  logic                    RST_NI,
    input  logic                    MODE_I,
    input  logic [DELAY_BITS-1:0]   DELAY_I,
    input  logic                    RW_TURN_I,
    input  logic                    WRITE_ALLOW_I,
    input  logic                    READ_ALLOW_I,
    output logic                    WRITE_O,
    output logic [ADDR_W-1:0]       WRITE_PTR_O,
    output logic [WIDTH-1:0]        DMEM_O,
    output logic [ADDR_W-1:0]       READ_PTR_O,
    input  logic [WIDTH-1:0]        DMEM_I,
    input  logic [NCHAN-1:0]        STORE_I,
    input  logic [NCHAN*WIDTH-1:0]  DATA_I,
    output logic [NCHAN-1:0]        STORE_PERM_O,
    input  logic                    TRG_EVENT_I,
    output logic                    TRG_DELAYED_O,
    output logic [ADDR_W-1:0]       EVENT_ADDR_O,
    input  logic                    LOAD_REQUEST_I,
    output logic                    LOAD_GRANT_O,
    output logic [WIDTH-1:0]        DATA_O,
    output logic [CHAN_W-1:0]       LAST_CHAN_O,
    output logic [15:0]             DROP_CNT_O
);

    localparam int HC_W = ADDR_W + DELAY_BITS + 1;
    localparam int CW1  = CHAN_W + 1;

    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] WP_STREAM = ADDR_W'(DEPTH / 2 - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] rp_q, rp_d;
    logic [CHAN_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [NCHAN-1:0]  pend_q, pend_d;
    logic [WIDTH-1:0]  slot_q [NCHAN];
    logic [WIDTH-1:0]  slot_d [NCHAN];
    logic              pend_rd_q, pend_rd_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              load_grant_q, load_grant_d;
    logic              trg_q, trg_d;
    logic              trg_delayed_q, trg_delayed_d;
    logic [ADDR_W-1:0] event_addr_q, event_addr_d;
    logic [CHAN_W-1:0] last_chan_q, last_chan_d;
    logic [HC_W-1:0]   hc_q, hc_d;

    // ------------------------------------------------------------------
    // Ring status and handshakes
    // ------------------------------------------------------------------
    logic              write_valid;
    logic              write_fire;
    logic              read_fire;
    logic              gnt_found;
    logic [CHAN_W-1:0] gnt_idx;
    logic [NCHAN-1:0]  gnt_oh;
    logic [CHAN_W-1:0] rr_next;
    logic [HC_W-1:0]   hc_load;

    assign write_valid = WRITE_ALLOW_I && ((wp_q + ONE_A) != rp_q) && !trg_delayed_q;
    assign write_fire  = RW_TURN_I && write_valid && gnt_found;
    assign read_fire   = pend_rd_q && !RW_TURN_I && READ_ALLOW_I && (rp_q != wp_q);

    // Round-robin search: first pending channel at or after rr_ptr.
    // The scan runs from the farthest offset down to offset 0, so the
    // last hit, which is the nearest channel, is the one kept.
    always_comb begin
        logic [CW1-1:0] cand;
        logic [CW1-1:0] rr_inc;
        cand      = '0;
        rr_inc    = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr_q} + CW1'(i);
            if (cand >= CW1'(NCHAN)) begin
                cand = cand - CW1'(NCHAN);
            end
            if (pend_q[cand[CHAN_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[CHAN_W-1:0];
            end
        end

        gnt_oh = '0;
        if (write_fire) begin
            gnt_oh[gnt_idx] = 1'b1;
        end

        rr_inc = {1'b0, gnt_idx} + CW1'(1);
        if (rr_inc >= CW1'(NCHAN)) begin
            rr_inc = '0;
        end
        rr_next = rr_inc[CHAN_W-1:0];
    end

    // Post-trigger history length: ((DELAY+1) * (DEPTH-1)) >> DELAY_BITS.
    // The product is below 2^(ADDR_W+DELAY_BITS), so HC_W bits hold it.
    always_comb begin
        hc_load = (HC_W'(DELAY_I) + HC_W'(1)) * HC_W'(DEPTH - 1);
        hc_load = hc_load >> DELAY_BITS;
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        wp_d          = wp_q;
        rp_d          = rp_q;
        rr_ptr_d      = rr_ptr_q;
        pend_d        = pend_q;
        slot_d        = slot_q;
        pend_rd_d     = pend_rd_q | LOAD_REQUEST_I;
        data_d        = data_q;
        load_grant_d  = 1'b0;
        trg_d         = trg_q;
        trg_delayed_d = trg_delayed_q;
        event_addr_d  = event_addr_q;
        last_chan_d   = last_chan_q;
        hc_d          = hc_q;

        if (write_fire) begin
            pend_d[gnt_idx] = 1'b0;
            wp_d            = wp_q + ONE_A;
            rr_ptr_d        = rr_next;
            last_chan_d     = gnt_idx;
        end

        // A slot being drained this cycle can accept a new word at once.
        for (int c = 0; c < NCHAN; c++) begin
            if (STORE_I[c] && (!pend_q[c] || gnt_oh[c])) begin
                slot_d[c] = DATA_I[c*WIDTH +: WIDTH];
                pend_d[c] = 1'b1;
            end
        end

        // The write in the trigger cycle itself is not counted: trg_q is
        // still low then, so hc keeps reloading.
        if (!trg_q) begin
            hc_d = hc_load;
            if (TRG_EVENT_I) begin
                trg_d        = 1'b1;
                event_addr_d = wp_q;
            end
        end else if (write_fire) begin
            if (hc_q == '0) begin
                trg_delayed_d = 1'b1;
            end else begin
                hc_d = hc_q - HC_W'(1);
            end
        end

        if (read_fire) begin
            data_d       = DMEM_I;
            load_grant_d = 1'b1;
            rp_d         = rp_q + ONE_A;
            pend_rd_d    = LOAD_REQUEST_I;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            wp_q          <= MODE_I ? WP_STREAM : '0;
            rp_q          <= MODE_I ? '0 : ONE_A;
            rr_ptr_q      <= '0;
            pend_q        <= '0;
            pend_rd_q     <= 1'b0;
            data_q        <= '0;
            load_grant_q  <= 1'b0;
            trg_q         <= 1'b0;
            trg_delayed_q <= 1'b0;
            event_addr_q  <= '0;
            last_chan_q   <= '0;
            hc_q          <= '0;
        end else begin
            wp_q          <= wp_d;
            rp_q          <= rp_d;
            rr_ptr_q      <= rr_ptr_d;
            pend_q        <= pend_d;
            pend_rd_q     <= pend_rd_d;
            data_q        <= data_d;
            load_grant_q  <= load_grant_d;
            trg_q         <= trg_d;
            trg_delayed_q <= trg_delayed_d;
            event_addr_q  <= event_addr_d;
            last_chan_q   <= last_chan_d;
            hc_q          <= hc_d;
        end
    end

    // Slot contents are only meaningful while pend is set, so they need
    // no reset.
    always_ff @(posedge CLK_I) begin
        slot_q <= slot_d;
    end

    // ------------------------------------------------------------------
    // Dropped-store counter
    // ------------------------------------------------------------------
`ifdef TRACE_LOGGER_MC_DROP_COUNT_EN
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic [NCHAN-1:0] drop_vec;
    logic [16:0]      drop_sum;

    always_comb begin
        drop_vec = STORE_I & pend_q & ~gnt_oh;
        drop_sum = {1'b0, drop_cnt_q};
        for (int c = 0; c < NCHAN; c++) begin
            drop_sum = drop_sum + 17'(drop_vec[c]);
        end
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign DROP_CNT_O = drop_cnt_q;
`else
    assign DROP_CNT_O = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign WRITE_O       = write_fire;
    assign WRITE_PTR_O   = wp_q;
    assign DMEM_O        = slot_q[gnt_idx];
    assign READ_PTR_O    = rp_q;
    assign STORE_PERM_O  = {NCHAN{write_valid}} & ~pend_q;
    assign TRG_DELAYED_O = trg_delayed_q;
    assign EVENT_ADDR_O  = event_addr_q;
    assign LOAD_GRANT_O  = load_grant_q;
    assign DATA_O        = data_q;
    assign LAST_CHAN_O   = last_chan_q;

endmodule

// File: tb/tb_trace_logger_mc.sv
// -----------------------------------------------------------------------------
// tb_trace_logger_mc
//
// Directed bench for trace_logger_mc with DEPTH=16 and NCHAN=2. The stimulus
// pushes the expected ring writes and read grants into queues. A monitor on
// the falling edge pops an entry and compares it whenever WRITE_O or
// LOAD_GRANT_O is high. The monitor also models the external memory.
// -----------------------------------------------------------------------------
module tb_trace_logger_mc;

    localparam int WIDTH      = 32;
    localparam int DEPTH      = 16;
    localparam int ADDR_W     = 4;
    localparam int NCHAN      = 2;
    localparam int CHAN_W     = 1;
    localparam int DELAY_BITS = 3;

`ifdef TRACE_LOGGER_MC_DROP_COUNT_EN
    localparam logic [31:0] DROP_EXP = 32'd1;
`else
    localparam logic [31:0] DROP_EXP = 32'd0;
`endif

    localparam logic [31:0] W_A  = 32'h1111_000A;
    localparam logic [31:0] W_B  = 32'h2222_000B;
    localparam logic [31:0] W_C0 = 32'h3333_00C0;
    localparam logic [31:0] W_C1 = 32'h3333_00C1;
    localparam logic [31:0] W_D0 = 32'h4444_00D0;
    localparam logic [31:0] W_D1 = 32'h4444_00D1;
    localparam logic [31:0] W_E0 = 32'h5555_00E0;
    localparam logic [31:0] W_E1 = 32'h5555_00E1;
    localparam logic [31:0] W_G  = 32'h6666_0006;
    localparam logic [31:0] W_H  = 32'h7777_0007;
    localparam logic [31:0] W_X  = 32'h8888_0008;

    logic                   CLK_I = 1'b0;
    logic                   RST_NI;
    logic                   MODE_I;
    logic [DELAY_BITS-1:0]  DELAY_I;
    logic                   RW_TURN_I;
    logic                   WRITE_ALLOW_I;
    logic                   READ_ALLOW_I;
    logic                   WRITE_O;
    logic [ADDR_W-1:0]      WRITE_PTR_O;
    logic [WIDTH-1:0]       DMEM_O;
    logic [ADDR_W-1:0]      READ_PTR_O;
    logic [WIDTH-1:0]       DMEM_I;
    logic [NCHAN-1:0]       STORE_I;
    logic [NCHAN*WIDTH-1:0] DATA_I;
    logic [NCHAN-1:0]       STORE_PERM_O;
    logic                   TRG_EVENT_I;
    logic                   TRG_DELAYED_O;
    logic [ADDR_W-1:0]      EVENT_ADDR_O;
    logic                   LOAD_REQUEST_I;
    logic                   LOAD_GRANT_O;
    logic [WIDTH-1:0]       DATA_O;
    logic [CHAN_W-1:0]      LAST_CHAN_O;
    logic [15:0]            DROP_CNT_O;

    trace_logger_mc #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .NCHAN(NCHAN), .CHAN_W(CHAN_W), .DELAY_BITS(DELAY_BITS)
    ) dut (
        .CLK_I(CLK_I), .RST_NI(RST_NI), .MODE_I(MODE_I), .DELAY_I(DELAY_I),
        .RW_TURN_I(RW_TURN_I), .WRITE_ALLOW_I(WRITE_ALLOW_I),
        .READ_ALLOW_I(READ_ALLOW_I), .WRITE_O(WRITE_O),
        .WRITE_PTR_O(WRITE_PTR_O), .DMEM_O(DMEM_O), .READ_PTR_O(READ_PTR_O),
        .DMEM_I(DMEM_I), .STORE_I(STORE_I), .DATA_I(DATA_I),
        .STORE_PERM_O(STORE_PERM_O), .TRG_EVENT_I(TRG_EVENT_I),
        .TRG_DELAYED_O(TRG_DELAYED_O), .EVENT_ADDR_O(EVENT_ADDR_O),
        .LOAD_REQUEST_I(LOAD_REQUEST_I), .LOAD_GRANT_O(LOAD_GRANT_O),
        .DATA_O(DATA_O), .LAST_CHAN_O(LAST_CHAN_O), .DROP_CNT_O(DROP_CNT_O)
    );

    always #5 CLK_I = ~CLK_I;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } wr_t;

    wr_t              wr_q[$];
    logic [WIDTH-1:0] rd_q[$];
    logic [WIDTH-1:0] mem [DEPTH];
    wr_t              mon_wr;
    logic [WIDTH-1:0] mon_rd;
    bit               mon_en = 1'b0;
    int               errors = 0;
    int               checks = 0;

    assign DMEM_I = mem[READ_PTR_O];

    // Memory model plus scoreboard. Before monitoring starts the memory is
    // loaded with an address-tagged pattern.
    always @(negedge CLK_I) begin
        if (!mon_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'hA5A5_0000 + 32'(i);
            end
        end else begin
            if (WRITE_O) begin
                mem[WRITE_PTR_O] <= DMEM_O;
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: got addr=%0d data=%h, none expected",
                             WRITE_PTR_O, DMEM_O);
                end else begin
                    mon_wr = wr_q.pop_front();
                    if (WRITE_PTR_O !== mon_wr.addr || DMEM_O !== mon_wr.data) begin
                        errors++;
                        $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                                 WRITE_PTR_O, DMEM_O, mon_wr.addr, mon_wr.data);
                    end
                end
            end
            if (LOAD_GRANT_O) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected: got data=%h, none expected", DATA_O);
                end else begin
                    mon_rd = rd_q.pop_front();
                    if (DATA_O !== mon_rd) begin
                        errors++;
                        $display("FAIL read: got data=%h expected %h", DATA_O, mon_rd);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK_I);
            #1;
        end
    endtask

    task automatic do_reset(input logic m);
        WRITE_ALLOW_I  = 1'b0;
        READ_ALLOW_I   = 1'b0;
        RW_TURN_I      = 1'b0;
        STORE_I        = '0;
        TRG_EVENT_I    = 1'b0;
        LOAD_REQUEST_I = 1'b0;
        RST_NI         = 1'b0;
        MODE_I         = m;
        tick(2);
        RST_NI = 1'b1;
        MODE_I = ~m;
    endtask

    // One-cycle store pulse followed by one idle cycle.
    task automatic store(input logic [NCHAN-1:0] st, input logic [31:0] d0, input logic [31:0] d1);
        STORE_I = st;
        DATA_I  = {d1, d0};
        tick(1);
        STORE_I = '0;
        tick(1);
    endtask

    task automatic do_read(input logic [31:0] exp);
        rd_q.push_back(exp);
        LOAD_REQUEST_I = 1'b1;
        tick(1);
        LOAD_REQUEST_I = 1'b0;
        tick(1);
    endtask

    task automatic push_wr(input int a, input logic [31:0] d);
        wr_t e;
        e.addr = ADDR_W'(a);
        e.data = d;
        wr_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_NI = 1'b0; MODE_I = 1'b0; DELAY_I = 3'b011; RW_TURN_I = 1'b0;
        WRITE_ALLOW_I = 1'b0; READ_ALLOW_I = 1'b0; STORE_I = '0; DATA_I = '0;
        TRG_EVENT_I = 1'b0; LOAD_REQUEST_I = 1'b0;

        // Trace-buffer reset: wp=0, rp=1, so the ring starts out full.
        do_reset(1'b0);
        mon_en = 1'b1;
        WRITE_ALLOW_I = 1'b1;
        READ_ALLOW_I  = 1'b1;
        #1;
        check("rst0_wp", 32'(WRITE_PTR_O), 32'd0);
        check("rst0_rp", 32'(READ_PTR_O), 32'd1);
        check("rst0_perm_full", 32'(STORE_PERM_O), 32'd0);
        check("rst0_grant", 32'(LOAD_GRANT_O), 32'd0);
        check("rst0_trg_delayed", 32'(TRG_DELAYED_O), 32'd0);
        check("rst0_event_addr", 32'(EVENT_ADDR_O), 32'd0);
        check("rst0_last_chan", 32'(LAST_CHAN_O), 32'd0);
        check("rst0_drop", 32'(DROP_CNT_O), 32'd0);
        check("rst0_data", DATA_O, 32'd0);

        // Drain the initial contents (addresses 1..15) until rp meets wp.
        for (int i = 1; i < DEPTH; i++) begin
            do_read(32'hA5A5_0000 + 32'(i));
        end
        tick(2);
        check("drain_rp", 32'(READ_PTR_O), 32'd0);
        check("drain_no_grant", 32'(LOAD_GRANT_O), 32'd0);

        // Both channels store together: A lands at 0, then B at 1.
        RW_TURN_I = 1'b1;
        #1;
        check("t1_perm", 32'(STORE_PERM_O), 32'd3);
        push_wr(0, W_A);
        push_wr(1, W_B);
        store(2'b11, W_A, W_B);
        tick(3);
        check("t1_wp", 32'(WRITE_PTR_O), 32'd2);
        check("t1_last_chan", 32'(LAST_CHAN_O), 32'd1);

        // Three all-channel stores, grants alternate 0,1,0,1,0,1.
        push_wr(2, W_C0); push_wr(3, W_C1);
        push_wr(4, W_D0); push_wr(5, W_D1);
        push_wr(6, W_E0); push_wr(7, W_E1);
        store(2'b11, W_C0, W_C1);
        store(2'b11, W_D0, W_D1);
        store(2'b11, W_E0, W_E1);
        tick(3);
        check("t2_wp", 32'(WRITE_PTR_O), 32'd8);
        check("t2_last_chan", 32'(LAST_CHAN_O), 32'd1);
        check("t2_drop", 32'(DROP_CNT_O), 32'd0);

        // Channel 0 stores twice during read turns: the second word is lost.
        RW_TURN_I = 1'b0;
        store(2'b01, W_G, 32'd0);
        store(2'b01, W_H, 32'd0);
        check("t3_drop", 32'(DROP_CNT_O), DROP_EXP);
        check("t3_perm_ch0_busy", 32'(STORE_PERM_O), 32'd2);
        push_wr(8, W_G);
        RW_TURN_I = 1'b1;
        tick(3);
        check("t3_wp", 32'(WRITE_PTR_O), 32'd9);
        check("t3_perm", 32'(STORE_PERM_O), 32'd3);

        // Streaming reset: wp=7, rp=0; one read returns mem[0].
        do_reset(1'b1);
        WRITE_ALLOW_I = 1'b1;
        READ_ALLOW_I  = 1'b1;
        #1;
        check("rst1_wp", 32'(WRITE_PTR_O), 32'd7);
        check("rst1_rp", 32'(READ_PTR_O), 32'd0);
        check("rst1_drop", 32'(DROP_CNT_O), 32'd0);
        check("rst1_last_chan", 32'(LAST_CHAN_O), 32'd0);
        do_read(W_A);
        tick(2);
        check("t5_rp", 32'(READ_PTR_O), 32'd1);
        check("t5_data", DATA_O, W_A);
        check("t5_grant_low", 32'(LOAD_GRANT_O), 32'd0);

        // Trigger at wp=7 with DELAY=3: hc=7, so 8 more writes (7..14).
        RW_TURN_I   = 1'b1;
        TRG_EVENT_I = 1'b1;
        tick(1);
        TRG_EVENT_I = 1'b0;
        tick(1);
        check("trg_event_addr", 32'(EVENT_ADDR_O), 32'd7);
        check("trg_not_delayed", 32'(TRG_DELAYED_O), 32'd0);
        push_wr(7,  32'hB000_0007); push_wr(8,  32'hB000_0008);
        push_wr(9,  32'hB000_0009); push_wr(10, 32'hB000_000A);
        push_wr(11, 32'hB000_000B); push_wr(12, 32'hB000_000C);
        push_wr(13, 32'hB000_000D);
        store(2'b11, 32'hB000_0007, 32'hB000_0008);
        store(2'b11, 32'hB000_0009, 32'hB000_000A);
        store(2'b11, 32'hB000_000B, 32'hB000_000C);
        store(2'b01, 32'hB000_000D, 32'd0);
        tick(1);
        check("trg_wp_after7", 32'(WRITE_PTR_O), 32'd14);
        check("trg_still_open", 32'(TRG_DELAYED_O), 32'd0);
        TRG_EVENT_I = 1'b1;
        tick(1);
        TRG_EVENT_I = 1'b0;
        check("trg_retrigger_ignored", 32'(EVENT_ADDR_O), 32'd7);
        push_wr(14, 32'hB000_000E);
        store(2'b10, 32'd0, 32'hB000_000E);
        tick(2);
        check("trg_wp_after8", 32'(WRITE_PTR_O), 32'd15);
        check("trg_delayed", 32'(TRG_DELAYED_O), 32'd1);
        check("trg_perm_blocked", 32'(STORE_PERM_O), 32'd0);
        store(2'b01, 32'hB000_000F, 32'd0);
        tick(3);
        check("trg_no_more_writes", 32'(WRITE_PTR_O), 32'd15);

        // Full ring: held word is written only after a read frees a slot.
        // The reset also discards the word left pending above.
        do_reset(1'b1);
        WRITE_ALLOW_I = 1'b1;
        READ_ALLOW_I  = 1'b1;
        RW_TURN_I     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_wr(7 + i, 32'hC000_0000 + 32'(i));
        end
        store(2'b11, 32'hC000_0000, 32'hC000_0001);
        store(2'b11, 32'hC000_0002, 32'hC000_0003);
        store(2'b11, 32'hC000_0004, 32'hC000_0005);
        store(2'b11, 32'hC000_0006, 32'hC000_0007);
        tick(3);
        check("full_wp", 32'(WRITE_PTR_O), 32'd15);
        check("full_perm", 32'(STORE_PERM_O), 32'd0);
        store(2'b10, 32'd0, W_X);
        tick(3);
        check("full_held_wp", 32'(WRITE_PTR_O), 32'd15);
        check("full_held_perm", 32'(STORE_PERM_O), 32'd0);
        RW_TURN_I = 1'b0;
        do_read(W_A);
        tick(1);
        check("full_read_rp", 32'(READ_PTR_O), 32'd1);
        push_wr(15, W_X);
        RW_TURN_I = 1'b1;
        tick(3);
        check("full_drain_wp", 32'(WRITE_PTR_O), 32'd0);
        check("full_again_perm", 32'(STORE_PERM_O), 32'd0);

        tick(2);
        check("wr_queue_empty", 32'(wr_q.size()), 32'd0);
        check("rd_queue_empty", 32'(rd_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trace_logger_mc.md
# trace_logger_mc

Multi-channel, parametrised trace logger between the tracer front-ends and the shared trace ring-buffer memory. Up to NCHAN tracers each hand over one WIDTH-bit word at a time. Words are merged round-robin into a single DEPTH-entry ring. Supports:
- pre/post-trigger history control;
- streaming mode;
- memory-to-interface readout via a request/grant handshake.

## Interface
- WIDTH, 32, trace word width.
- DEPTH, 1024, ring entries; power of two, ≥4.
- ADDR_W, $clog2(DEPTH), pointer width.
- NCHAN, 2, number of trace channels, 1..8.
- CHAN_W, (NCHAN>1 ? $clog2(NCHAN) : 1), channel index width.
- DELAY_BITS, 3, width of trigger-delay ratio field.

Ports:
- CLK_I  in  1  single clock, all logic on rising edge.
- RST_NI  in  1  reset, synchronous, active-low.
- MODE_I  in  1  0 = trace-buffer mode, 1 = streaming mode; sampled only while RST_NI=0.
- DELAY_I  in  DELAY_BITS  post-trigger ratio.
- RW_TURN_I  in  1  1 = write cycle, 0 = read cycle.
- WRITE_ALLOW_I / READ_ALLOW_I  in  1 each  memory-side permission.
- WRITE_O  out  1  memory write strobe.
- WRITE_PTR_O  out  ADDR_W  memory write address.
- DMEM_O  out  WIDTH  memory write data.
- READ_PTR_O  out  ADDR_W  memory read address.
- DMEM_I  in  WIDTH  memory data at READ_PTR_O, valid same cycle.
- STORE_I  in  NCHAN  per-channel store strobe.
- DATA_I  in  NCHAN*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- STORE_PERM_O  out  NCHAN  channel may issue STORE_I.
- TRG_EVENT_I  in  1  trigger event.
- TRG_DELAYED_O  out  1  trigger seen and post-trigger history complete.
- EVENT_ADDR_O  out  ADDR_W  write pointer when trigger was first seen.
- LOAD_REQUEST_I  in  1  readout request.
- LOAD_GRANT_O  out  1  one-cycle grant; DATA_O valid.
- DATA_O  out  WIDTH  read data.
- LAST_CHAN_O  out  CHAN_W  channel of the most recent write.
- DROP_CNT_O  out  16  dropped-store count (see Configuration).

## Operation
- Per-channel one-entry slot: `pend[c]` plus `slot[c]`.
- STORE_I[c] with `pend[c]=0`, or with `pend[c]` granted in the same cycle: latch DATA_I[c] into `slot[c]`, set `pend[c]`.
- STORE_I[c] with `pend[c]=1` and not granted that cycle: store is dropped; `slot[c]` is unchanged.
- `write_valid = WRITE_ALLOW_I && ((wp+1) mod DEPTH) != rp && !TRG_DELAYED_O`.
- `STORE_PERM_O[c] = write_valid && !pend[c]`.
- Arbiter:
  - Runs when RW_TURN_I=1 && write_valid && any pend.
  - Grants the first pending channel at or after `rr_ptr`, cyclically.
  - Grant: WRITE_O=1 (combinational); DMEM_O = granted slot (combinational); next edge clears `pend`, `wp<=wp+1` (wraps), `rr_ptr<=grant+1` (wraps), LAST_CHAN_O<=grant.
  - At most one write per cycle.
- Read:
  - LOAD_REQUEST_I sets `pend_rd`.
  - When `pend_rd && !RW_TURN_I && READ_ALLOW_I && rp != wp`: DATA_O<=DMEM_I, LOAD_GRANT_O<=1 for one cycle, `rp<=rp+1` (wraps), `pend_rd` cleared.
  - If LOAD_REQUEST_I is high in the granting cycle, `pend_rd` stays set.
- Trigger:
  - First cycle with TRG_EVENT_I=1: EVENT_ADDR_O<=wp, sticky `trg` set.
  - Later triggers are ignored until reset.
- History counter `hc`:
  - While `trg=0`, reload `hc = ((DELAY_I+1)*(DEPTH-1)) >> DELAY_BITS`, computed at ADDR_W+DELAY_BITS+1 bits.
  - While `trg=1`, each write decrements `hc`.
  - A write with `hc=0` sets TRG_DELAYED_O (sticky). This blocks further writes from the next cycle on.

## Timing
- Reset values:
  - MODE_I=0: wp=0, rp=1.
  - MODE_I=1: wp=DEPTH/2-1, rp=0.
  - Cleared to 0: `pend`, `pend_rd`, `rr_ptr`, DATA_O, LOAD_GRANT_O, TRG_DELAYED_O, EVENT_ADDR_O, LAST_CHAN_O, DROP_CNT_O.
  - Combinational outputs follow from the reset state.
- Store latency: STORE_I at edge t gives earliest WRITE_O in cycle t+1 (requires RW_TURN_I=1).
- Read latency: request at t gives earliest grant at t+1 edge (requires !RW_TURN_I).
- Full ring (wp+1=rp): pends are held with no loss; STORE_PERM_O=0.
- Empty ring (rp=wp): reads stall.
- Trigger and write in the same cycle: EVENT_ADDR_O takes the pre-increment wp; that write does not decrement `hc`.
- Reset mid-operation: all slots and pending requests are discarded.

## Configuration
- TRACE_LOGGER_MC_DROP_COUNT_EN defined: DROP_CNT_O increments by the number of dropped stores per cycle and saturates at 16'hFFFF.
- Not defined: DROP_CNT_O tied to 0 and no counter logic is generated.

## Test plan
- NCHAN=2, DEPTH=16; STORE_I=2'b11 with A/B, RW_TURN_I=1 constant -> writes A@0, B@1; LAST_CHAN_O=1; wp=2.
- Three consecutive all-channel stores with RW_TURN_I=1 -> grant order 0,1,0,1,0,1; no drops; DROP_CNT_O=0.
- Channel 0 stores twice with RW_TURN_I=0 -> second store dropped; DROP_CNT_O=1 with macro, 0 without; first word is retained.
- DELAY_I=3'b011, DEPTH=16, trigger at wp=5 -> EVENT_ADDR_O=5; `hc`=7; TRG_DELAYED_O rises after the 8th post-trigger write (wp=13); no further WRITE_O.
- MODE_I=1 at reset -> wp=7, rp=0; LOAD_REQUEST_I with !RW_TURN_I -> one LOAD_GRANT_O pulse, DATA_O=mem[0], rp=1.
- Fill to wp+1=rp -> STORE_PERM_O=0; one read frees a slot and the pending word is written on the next turn.
